surf_align_sequencer: RTL and testbench
=======================================

Name: surf_align_sequencer

Overview:
Autonomous alignment controller for one SURF link's COUT or DOUT path. It acts as a Wishbone master on the 6-bit-address SURF control register space. It resets the ISERDES, programs the bit-error interval, sweeps IDELAY taps, and centres the IDELAY in the widest error-free eye. It then bitslips until the training pattern is seen and sets the path enable. It replaces the software-driven alignment loop and sits between the TURFIO control crossbar and the SURF control register block.

Parameters:
NTAPS, 32, IDELAY taps swept (0..NTAPS-1), max 64
INTERVAL, 24'd131072, bit-error count interval written to the error-count register
SETTLE, 300000, wb_clk cycles waited after each IDELAY write before reading the count; must exceed 2 intervals plus crossing latency
ERR_THRESH, 0, a tap is "good" if its count <= ERR_THRESH
MIN_EYE, 4, minimum good-run length accepted
PAT_WIDTH, 8, low data bits compared against the pattern
TRAIN_PATTERN, 8'hA9, expected training word
MAX_SLIPS, 8, bitslips attempted before failure
TIMEOUT, 1023, wb_clk cycles allowed for ack per transaction

Ports:
wb_clk_i  in  1  Wishbone clock; sole clock
wb_rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  one-cycle pulse; ignored unless IDLE/DONE/FAIL
chan_i  in  1  0=COUT (base 0x00), 1=DOUT (base 0x10); sampled on start
m_cyc_o, m_stb_o, m_we_o  out  1 each  master strobes
m_adr_o  out  6  base + {0x0 control, 0x4 idelay, 0x8 error count, 0xC data}
m_dat_o  out  32  write data
m_sel_o  out  4  always 4'hF
m_dat_i  in  32  read data
m_ack_i, m_err_i  in  1 each  termination
busy_o  out  1  high outside IDLE/DONE/FAIL
done_o, fail_o  out  1 each  sticky status until next start
fail_code_o  out  2  0 timeout/err, 1 eye too small, 2 slips exhausted
eye_start_o, eye_len_o, tap_o  out  6 each  best-run start, length, programmed centre tap
slips_o  out  4  bitslips issued

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; cyc/stb/we low.
- Bus: one transaction at a time. cyc=stb held with fixed adr/dat/we until ack or err. The cycle after termination drops cyc/stb, with at least one idle cycle between transactions. err, or no ack within TIMEOUT cycles: FAIL, code 0.
- Read data 32'hFFFFFFFF from the error-count register means the sysclk side is down. The tap is treated as bad.
- States, in order:
  - IDLE/DONE/FAIL: start sets busy and clears done/fail/status, then goes to RST_RD.
  - RST_RD: read control into shadow.
  - RST_SET: write shadow | bit2 (ISERDES reset).
  - RST_CLR: write shadow & ~bit2 & ~bit8.
  - INTV: write {8'h0, INTERVAL} to the error-count register; this also selects the channel's error source.
  - TAP_WR: write tap to the idelay register.
  - TAP_WAIT: count SETTLE cycles.
  - TAP_RD: read the error count, then EVAL.
  - EVAL: update run tracking. If tap==NTAPS-1, go to CTR; else tap+1 and TAP_WR.
  - CTR: if best_len<MIN_EYE, FAIL code 1. Otherwise write tap = best_start + (best_len>>1) and set tap_o.
  - SLIP_RD: read data. Match on low PAT_WIDTH bits == TRAIN_PATTERN goes to EN_RD. On mismatch, if slips==MAX_SLIPS then FAIL code 2; else SLIP_WR.
  - SLIP_WR: write to data register (bitslip), slips+1, back to SLIP_RD.
  - EN_RD/EN_WR: read control, write it back with bit8 set, then DONE.
- Run tracking, 7-bit internally, with no wrap across tap NTAPS-1 to 0:
  - Good tap: cur_len+1.
  - Bad tap: cur_len=0, cur_start=tap+1.
  - After each good tap, if cur_len > best_len then best = cur. Strict compare, so the earliest run wins ties.
- start_i while busy: ignored.
- Reset mid-transaction: bus released immediately, with no completion.
- m_ack_i while cyc low: ignored.
- Only control bits 2 and 8 are modified; all other read-back bits are preserved.

Test Plan:
- Model all taps error-free, chan=0, NTAPS=32 -> eye_start=0, eye_len=32, tap_o=16; idelay write 16 at 0x04; done_o=1.
- chan=1, errors on taps 0-9 and 20-31 -> eye 10/10, tap_o=15; all addresses in 0x10-0x1C; control bit8 written at 0x10.
- Two 6-tap good runs at 3-8 and 20-25 -> earliest chosen: eye_start=3, tap_o=6.
- Good only at taps 5-7 with MIN_EYE=4 -> fail_o=1, fail_code=1, no enable write.
- Data model matches 8'hA9 after 3 slips -> slips_o=3, done; never matches -> 8 slips then fail_code=2.
- Slave withholds ack on the INTV write -> fail_code=0 after 1023 cycles, cyc low. Reset asserted mid-sweep -> all outputs 0 immediately, and a new start completes normally.

Source files
------------

// File: rtl/surf_align_sequencer_if.sv
// Wishbone master/slave bundle between the alignment sequencer and the SURF
// control register block (6-bit address, 32-bit data).
interface surf_align_sequencer_if;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic [5:0]  m_adr_o;
  logic [31:0] m_dat_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i;
  logic        m_err_i;

  modport master (
    output m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, m_sel_o,
    input  m_dat_i, m_ack_i, m_err_i
  );

  modport slave (
    input  m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, m_sel_o,
    output m_dat_i, m_ack_i, m_err_i
  );
endinterface

// File: rtl/surf_align_sequencer.sv
// Autonomous SURF link alignment: ISERDES reset, IDELAY eye sweep and centring,
// bitslip to the training word, then path enable, all over a Wishbone master.
module surf_align_sequencer #(
  parameter int unsigned          NTAPS         = 32,
  parameter logic [23:0]          INTERVAL      = 24'd131072,
  parameter int unsigned          SETTLE        = 300000,
  parameter int unsigned          ERR_THRESH    = 0,
  parameter int unsigned          MIN_EYE       = 4,
  parameter int unsigned          PAT_WIDTH     = 8,
  parameter logic [PAT_WIDTH-1:0] TRAIN_PATTERN = PAT_WIDTH'(8'hA9),
  parameter int unsigned          MAX_SLIPS     = 8,
  parameter int unsigned          TIMEOUT       = 1023
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_n_i,
  input  logic                          start_i,
  input  logic                          chan_i,
  surf_align_sequencer_if.master        bus,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          fail_o,
  output logic [1:0]                    fail_code_o,
  output logic [5:0]                    eye_start_o,
  output logic [5:0]                    eye_len_o,
  output logic [5:0]                    tap_o,
  output logic [3:0]                    slips_o
);

  localparam int unsigned SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [5:0]  OffCtrl   = 6'h0;
  localparam logic [5:0]  OffIdly   = 6'h4;
  localparam logic [5:0]  OffErr    = 6'h8;
  localparam logic [5:0]  OffData   = 6'hC;
  localparam logic [31:0] CtrlIsRst = 32'h0000_0004;
  localparam logic [31:0] CtrlEn    = 32'h0000_0100;

  typedef enum logic [3:0] {
    StIdle, StRstRd, StRstSet, StRstClr, StIntv, StTapWr, StTapWait, StTapRd,
    StEval, StCtr, StSlipRd, StSlipWr, StEnRd, StEnWr, StDone, StFail
  } state_e;

  state_e          state_q;
  logic            cyc_q, we_q, chan_q;
  logic [5:0]      adr_q;
  logic [31:0]     dat_q, shadow_q, rd_q;
  logic [TmoW-1:0] tmo_q;
  logic [SetW-1:0] settle_q;
  logic [6:0]      tap_q, cur_start_q, cur_len_q, best_start_q, best_len_q;

  logic            is_bus, req_we, good, pat_match;
  logic [5:0]      req_off, base;
  logic [31:0]     req_dat;
  logic [6:0]      cur_len_inc, ctr_tap;

  assign base        = chan_q ? 6'h10 : 6'h00;
  // All-ones read-back means the sysclk side is not running: never a good tap.
  assign good        = (rd_q != 32'hFFFF_FFFF) && (rd_q <= ERR_THRESH);
  assign cur_len_inc = cur_len_q + 7'd1;
  assign ctr_tap     = best_start_q + (best_len_q >> 1);
  assign pat_match   = bus.m_dat_i[PAT_WIDTH-1:0] == TRAIN_PATTERN;

  assign bus.m_cyc_o = cyc_q;
  assign bus.m_stb_o = cyc_q;
  assign bus.m_we_o  = we_q;
  assign bus.m_adr_o = adr_q;
  assign bus.m_dat_o = dat_q;
  assign bus.m_sel_o = 4'hF;

  always_comb begin
    is_bus  = 1'b1;
    req_we  = 1'b0;
    req_off = OffCtrl;
    req_dat = '0;
    case (state_q)
      StRstRd:  ;
      StRstSet: begin req_we = 1'b1; req_dat = shadow_q | CtrlIsRst; end
      StRstClr: begin req_we = 1'b1; req_dat = shadow_q & ~(CtrlIsRst | CtrlEn); end
      StIntv:   begin req_we = 1'b1; req_off = OffErr; req_dat = {8'h00, INTERVAL}; end
      StTapWr:  begin req_we = 1'b1; req_off = OffIdly; req_dat = {26'h0, tap_q[5:0]}; end
      StTapRd:  req_off = OffErr;
      StCtr:    begin req_we = 1'b1; req_off = OffIdly; req_dat = {26'h0, ctr_tap[5:0]}; end
      StSlipRd: req_off = OffData;
      StSlipWr: begin req_we = 1'b1; req_off = OffData; end
      StEnRd:   ;
      StEnWr:   begin req_we = 1'b1; req_dat = shadow_q | CtrlEn; end
      default:  is_bus = 1'b0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= StIdle;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      chan_q       <= 1'b0;
      shadow_q     <= '0;
      rd_q         <= '0;
      tmo_q        <= '0;
      settle_q     <= '0;
      tap_q        <= '0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      fail_o       <= 1'b0;
      fail_code_o  <= '0;
      eye_start_o  <= '0;
      eye_len_o    <= '0;
      tap_o        <= '0;
      slips_o      <= '0;
    end else begin
      case (state_q)
        StIdle, StDone, StFail: begin
          if (start_i) begin
            state_q      <= StRstRd;
            chan_q       <= chan_i;
            busy_o       <= 1'b1;
            done_o       <= 1'b0;
            fail_o       <= 1'b0;
            fail_code_o  <= '0;
            eye_start_o  <= '0;
            eye_len_o    <= '0;
            tap_o        <= '0;
            slips_o      <= '0;
            tap_q        <= '0;
            settle_q     <= '0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
          end
        end
        StTapWait: begin
          if (settle_q == SetW'(SETTLE - 1)) begin
            settle_q <= '0;
            state_q  <= StTapRd;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        StEval: begin
          // Strict compare keeps the earliest of equally long runs.
          if (good) begin
            cur_len_q <= cur_len_inc;
            if (cur_len_inc > best_len_q) begin
              best_len_q   <= cur_len_inc;
              best_start_q <= cur_start_q;
            end
          end else begin
            cur_len_q   <= '0;
            cur_start_q <= tap_q + 7'd1;
          end
          if (tap_q == 7'(NTAPS - 1)) begin
            state_q <= StCtr;
          end else begin
            tap_q   <= tap_q + 7'd1;
            state_q <= StTapWr;
          end
        end
        default: begin
          if (is_bus && !cyc_q) begin
            if (state_q == StCtr) begin
              eye_start_o <= best_start_q[5:0];
              eye_len_o   <= (best_len_q > 7'd63) ? 6'd63 : best_len_q[5:0];
            end
            if (state_q == StCtr && best_len_q < 7'(MIN_EYE)) begin
              state_q     <= StFail;
              fail_o      <= 1'b1;
              fail_code_o <= 2'd1;
              busy_o      <= 1'b0;
            end else begin
              cyc_q <= 1'b1;
              we_q  <= req_we;
              adr_q <= base | req_off;
              dat_q <= req_dat;
              tmo_q <= '0;
            end
          end else if (is_bus) begin
            if (bus.m_err_i || (!bus.m_ack_i && tmo_q == TmoW'(TIMEOUT - 1))) begin
              cyc_q       <= 1'b0;
              we_q        <= 1'b0;
              state_q     <= StFail;
              fail_o      <= 1'b1;
              fail_code_o <= 2'd0;
              busy_o      <= 1'b0;
            end else if (bus.m_ack_i) begin
              cyc_q <= 1'b0;
              we_q  <= 1'b0;
              case (state_q)
                StRstRd:  begin shadow_q <= bus.m_dat_i; state_q <= StRstSet; end
                StRstSet: state_q <= StRstClr;
                StRstClr: state_q <= StIntv;
                StIntv:   state_q <= StTapWr;
                StTapWr:  state_q <= StTapWait;
                StTapRd:  begin rd_q <= bus.m_dat_i; state_q <= StEval; end
                StCtr:    begin tap_o <= ctr_tap[5:0]; state_q <= StSlipRd; end
                StSlipRd: begin
                  if (pat_match) begin
                    state_q <= StEnRd;
                  end else if (slips_o == 4'(MAX_SLIPS)) begin
                    state_q     <= StFail;
                    fail_o      <= 1'b1;
                    fail_code_o <= 2'd2;
                    busy_o      <= 1'b0;
                  end else begin
                    state_q <= StSlipWr;
                  end
                end
                StSlipWr: begin slips_o <= slips_o + 4'd1; state_q <= StSlipRd; end
                StEnRd:   begin shadow_q <= bus.m_dat_i; state_q <= StEnWr; end
                StEnWr:   begin state_q <= StDone; done_o <= 1'b1; busy_o <= 1'b0; end
                default:  state_q <= StIdle;
              endcase
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_surf_align_sequencer.sv
// Randomised scoreboard bench: a high-level model predicts the Wishbone
// transaction stream and final status; a monitor checks every transaction.
module tb_surf_align_sequencer;
  localparam int unsigned NT   = 32;
  localparam int unsigned TMO  = 1023;
  localparam int          MAXS = 8;

  typedef struct {
    logic        we;
    logic [5:0]  adr;
    logic [31:0] dat;
    logic        chk_dat;
  } txn_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, chan = 1'b0;
  logic busy, done, fail;
  logic [1:0] fcode;
  logic [5:0] estart, elen, tap;
  logic [3:0] slips;

  surf_align_sequencer_if bus();

  surf_align_sequencer #(.SETTLE(20)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .start_i     (start),
    .chan_i      (chan),
    .bus         (bus),
    .busy_o      (busy),
    .done_o      (done),
    .fail_o      (fail),
    .fail_code_o (fcode),
    .eye_start_o (estart),
    .eye_len_o   (elen),
    .tap_o       (tap),
    .slips_o     (slips)
  );

  always #5 clk = ~clk;

  txn_t exp_q[$];
  int n_tests = 0, n_fail = 0, last_len = 0;
  logic [63:0] cfg_good = '0;
  int cfg_match = 0;
  bit cfg_hold = 0;
  logic [31:0] sl_ctrl = '0, sl_idly = '0;
  int sl_slips = 0;
  int e_done, e_fail, e_code, e_start, e_len, e_tap, e_slips;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic we, input logic [5:0] adr, input logic [31:0] dat,
                      input logic chk);
    txn_t t;
    t.we = we; t.adr = adr; t.dat = dat; t.chk_dat = chk;
    exp_q.push_back(t);
  endtask

  // Reference: expected bus traffic and final status from the alignment rules.
  task automatic model(input logic ch, input logic [63:0] gm, input int m,
                       input logic [31:0] ctrl0, input bit hold);
    logic [5:0] b;
    logic [31:0] cr;
    int bs, bl, t, s;
    b = ch ? 6'h10 : 6'h00;
    e_done = 0; e_fail = 0; e_code = 0; e_start = 0; e_len = 0; e_tap = 0; e_slips = 0;
    cr = ctrl0 & ~32'h104;
    push(1'b0, b, '0, 1'b0);
    push(1'b1, b, ctrl0 | 32'h4, 1'b1);
    push(1'b1, b, cr, 1'b1);
    push(1'b1, b + 6'h8, 32'h0002_0000, 1'b1);
    if (hold) begin e_fail = 1; return; end
    for (int i = 0; i < int'(NT); i++) begin
      push(1'b1, b + 6'h4, 32'(i), 1'b1);
      push(1'b0, b + 6'h8, '0, 1'b0);
    end
    bs = 0; bl = 0; t = 0;
    while (t < int'(NT)) begin
      if (gm[t]) begin
        s = t;
        while (t < int'(NT) && gm[t]) t++;
        if (t - s > bl) begin bl = t - s; bs = s; end
      end else begin
        t++;
      end
    end
    e_start = bs; e_len = bl;
    if (bl < 4) begin e_fail = 1; e_code = 1; return; end
    e_tap = bs + bl / 2;
    push(1'b1, b + 6'h4, 32'(e_tap), 1'b1);
    for (int k = 0; k <= MAXS; k++) begin
      push(1'b0, b + 6'hC, '0, 1'b0);
      if (k == m) begin
        e_slips = k; e_done = 1;
        push(1'b0, b, '0, 1'b0);
        push(1'b1, b, cr | 32'h100, 1'b1);
        return;
      end
      if (k == MAXS) begin e_slips = MAXS; e_fail = 1; e_code = 2; return; end
      push(1'b1, b + 6'hC, '0, 1'b0);
    end
  endtask

  // Slave: random ack latency, stray acks while idle, register side effects.
  initial begin
    int lat;
    bit act;
    logic [31:0] r;
    lat = 0; act = 0;
    bus.m_ack_i = 1'b0; bus.m_err_i = 1'b0; bus.m_dat_i = '0;
    forever begin
      @(negedge clk);
      bus.m_ack_i = 1'b0;
      if (bus.m_cyc_o && bus.m_stb_o) begin
        if (!act) begin act = 1; lat = $urandom_range(0, 3); end
        if (!(cfg_hold && bus.m_we_o && bus.m_adr_o[3:0] == 4'h8)) begin
          if (lat > 0) begin
            lat--;
          end else begin
            act = 0;
            bus.m_ack_i = 1'b1;
            r = $urandom;
            case (bus.m_adr_o[3:0])
              4'h0: if (bus.m_we_o) sl_ctrl = bus.m_dat_o; else r = sl_ctrl;
              4'h4: if (bus.m_we_o) sl_idly = bus.m_dat_o; else r = sl_idly;
              4'h8: if (!bus.m_we_o) begin
                if (cfg_good[sl_idly[5:0]]) r = '0;
                else if (r[0]) r = 32'hFFFF_FFFF;
                else r = {20'h0, r[12:1]} + 32'd1;
              end
              default: if (bus.m_we_o) sl_slips++;
                       else if (sl_slips == cfg_match) r[7:0] = 8'hA9;
                       else if (r[7:0] == 8'hA9) r[7:0] = 8'h00;
            endcase
            bus.m_dat_i = r;
          end
        end
      end else begin
        act = 0;
        bus.m_ack_i = ($urandom_range(0, 7) == 0);
        bus.m_dat_i = $urandom;
      end
    end
  end

  // Monitor: pop and compare on each new transaction; check hold stability.
  initial begin
    logic prev = 1'b0;
    bit stable = 1;
    int hi = 0;
    txn_t cap, e;
    forever begin
      @(negedge clk);
      if (bus.m_cyc_o && !prev) begin
        cap.we = bus.m_we_o; cap.adr = bus.m_adr_o; cap.dat = bus.m_dat_o;
        stable = 1; hi = 0;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL txn_unexpected: got we=%0b adr=0x%0h dat=0x%0h, expected none",
                   cap.we, cap.adr, cap.dat);
        end else begin
          e = exp_q.pop_front();
          if (cap.we !== e.we || cap.adr !== e.adr || (e.chk_dat && cap.dat !== e.dat) ||
              bus.m_stb_o !== 1'b1 || bus.m_sel_o !== 4'hF) begin
            n_fail++;
            $display("FAIL txn: got we=%0b adr=0x%0h dat=0x%0h sel=%h, expected we=%0b adr=0x%0h dat=0x%0h sel=f",
                     cap.we, cap.adr, cap.dat, bus.m_sel_o, e.we, e.adr, e.dat);
          end
        end
      end
      if (bus.m_cyc_o) begin
        hi++;
        if (bus.m_we_o !== cap.we || bus.m_adr_o !== cap.adr || bus.m_dat_o !== cap.dat ||
            bus.m_stb_o !== 1'b1) stable = 0;
      end
      if (!bus.m_cyc_o && prev) begin
        last_len = hi;
        check("txn_stable", 32'(stable), 32'd1);
      end
      prev = bus.m_cyc_o;
    end
  end

  task automatic launch_case(input logic ch, input logic [63:0] gm, input int m, input bit hold);
    logic [31:0] c0;
    c0 = $urandom;
    cfg_good = gm; cfg_match = m; cfg_hold = hold;
    sl_ctrl = c0; sl_idly = '0; sl_slips = 0;
    model(ch, gm, m, c0, hold);
    start = 1'b1; chan = ch;
    @(negedge clk);
    start = 1'b0; chan = ~ch;
    check("busy_on_start", 32'(busy), 32'd1);
  endtask

  task automatic finish_case(input string tag, input bit hold);
    int cnt;
    cnt = 0;
    while (busy && cnt < 20000) begin @(negedge clk); cnt++; end
    check({tag, "_terminates"}, 32'(cnt < 20000), 32'd1);
    check({tag, "_done"}, 32'(done), 32'(e_done));
    check({tag, "_fail"}, 32'(fail), 32'(e_fail));
    check({tag, "_fail_code"}, 32'(fcode), 32'(e_code));
    check({tag, "_no_missing_txn"}, 32'(exp_q.size()), 32'd0);
    if (e_done == 1 || e_code == 2) begin
      check({tag, "_eye_start"}, 32'(estart), 32'(e_start));
      check({tag, "_eye_len"}, 32'(elen), 32'(e_len));
      check({tag, "_tap"}, 32'(tap), 32'(e_tap));
      check({tag, "_slips"}, 32'(slips), 32'(e_slips));
    end
    if (hold) begin
      check({tag, "_cyc_low"}, 32'(bus.m_cyc_o), 32'd0);
      check({tag, "_timeout_len"}, 32'(last_len), 32'(TMO));
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bus_ctl"}, {23'h0, bus.m_cyc_o, bus.m_stb_o, bus.m_we_o, bus.m_adr_o}, '0);
    check({tag, "_bus_dat"}, bus.m_dat_o, '0);
    check({tag, "_status"}, {5'h0, busy, done, fail, fcode, estart, elen, tap, slips}, '0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected finish within budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] gm;
    int s, l;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    launch_case(1'b0, 64'h0000_0000_FFFF_FFFF, 0, 0);
    finish_case("all_good", 0);
    launch_case(1'b1, 64'h0000_0000_000F_FC00, 2, 0);
    finish_case("dout_eye10", 0);
    launch_case(1'b0, 64'h0000_0000_03F0_01F8, 1, 0);
    finish_case("tie_earliest", 0);
    launch_case(1'b1, 64'h0000_0000_0000_00E0, 0, 0);
    finish_case("eye_small", 0);

    launch_case(1'b0, 64'h0000_0000_0FFF_F000, 3, 0);
    repeat (100) @(negedge clk);
    start = 1'b1; chan = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_case("slips3_busy_start", 0);

    launch_case(1'b1, 64'h0000_0000_FF00_00FF, 99, 0);
    finish_case("slips_exhausted", 0);
    launch_case(1'b0, 64'h0000_0000_FFFF_FFFF, 0, 1);
    finish_case("ack_timeout", 1);

    launch_case(1'b0, 64'h0000_0000_FFFF_FFFF, 1, 0);
    repeat (300) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'(busy), 32'd0);
    launch_case(1'b1, 64'h0000_0000_00FF_FF00, 4, 0);
    finish_case("after_reset", 0);

    for (int n = 0; n < 4; n++) begin
      gm = '0;
      for (int r = 0; r < int'($urandom_range(1, 3)); r++) begin
        s = $urandom_range(0, 31);
        l = $urandom_range(1, 12);
        for (int j = s; j < s + l && j < 32; j++) gm[j] = 1'b1;
      end
      launch_case(1'($urandom_range(0, 1)), gm, $urandom_range(0, 9), 0);
      finish_case("random", 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
